vga_sync_stream: RTL and testbench
==================================

// Module: vga_sync_stream
// PURPOSE
//  Head of the RGB-stream pipeline: generates 800x600 VGA timing and emits the 26-bit stream word
//  (Active, VS, HS, YC, XC, RGB) consumed by the first overlay stage (register/char drawers).
//  Fills the visible area with a background colour; downstream stages overwrite RGB in place.
//  Also emits a one-cycle start-of-frame pulse for frame-synchronous logic.
// PARAMETERS
//  H_VIS   800  visible pixels per line
//  H_FP    56   horizontal front porch (pixels)
//  H_SYNC  120  horizontal sync width (pixels)
//  H_BP    64   horizontal back porch (pixels)
//  V_VIS   600  visible lines per frame
//  V_FP    37   vertical front porch (lines)
//  V_SYNC  6    vertical sync width (lines)
//  V_BP    23   vertical back porch (lines)
//  HS_POL  1    HS level while in sync pulse (1 = active-high)
//  VS_POL  1    VS level while in sync pulse (1 = active-high)
// PORTS
//  px_clk    in   1   pixel clock (50 MHz for defaults = 800x600@72)
//  reset     in   1   asynchronous, active-high reset
//  bg_color  in   3   background {B,G,R} for visible pixels, sampled every cycle
//  strRGB_o  out  26  stream: [0]Active [1]VS [2]HS [12:3]YC [22:13]XC [23]R [24]G [25]B
//  frame_o   out  1   one-cycle pulse, coincident with stream word XC=0,YC=0
// BEHAVIOUR
//  - Internal counters hc, vc: 11 bits each. H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (1040).
//    V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (666).
//  - Each px_clk edge: hc <= (hc==H_TOTAL-1) ? 0 : hc+1. vc advances only when hc wraps.
//    vc <= (vc==V_TOTAL-1) ? 0 : vc+1.
//  - strRGB_o and frame_o are registered from the current (hc,vc): 1-cycle latency.
//    All fields of one word always describe the same (hc,vc); no field skew.
//  - Active = (hc < H_VIS) && (vc < V_VIS).
//  - HS = HS_POL when H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC (856..975), else ~HS_POL.
//  - VS = VS_POL when V_VIS+V_FP <= vc < V_VIS+V_FP+V_SYNC (637..642), else ~VS_POL.
//    VS depends on vc only and does not wait for HS.
//  - Active=1: XC = hc[9:0], YC = vc[9:0], RGB = bg_color as sampled that cycle.
//  - Active=0: XC = 0, YC = 0, RGB = 3'b000 (blanking forced; 10-bit fields never overflow).
//  - frame_o = 1 for exactly the word with hc==0 && vc==0, once per frame.
//  - Reset (async assert, any time incl. mid-line): hc=vc=0, strRGB_o=26'h0, frame_o=0 immediately.
//    HS/VS bits read 0 during reset regardless of polarity.
//  - After reset release, first edge: word for (0,0) (Active=1, frame_o=1, HS/VS inactive).
//    Counters go to hc=1. Frame period is H_TOTAL*V_TOTAL = 692640 cycles.
//  - Parameter rule: H_VIS, V_VIS <= 1024; totals < 2048. Non-compliant values are unsupported.
// TESTING
//  1 Reset: assert reset mid-line (hc~400) -> strRGB_o=0, frame_o=0 immediately.
//    Release -> next word XC=0,YC=0,Active=1,frame_o=1.
//  2 Line timing: bg_color=3'b101; line 0 words 0..799 Active=1, RGB=101, XC=0..799.
//    Word 800 Active=0, XC=0, RGB=000. HS=1 exactly at words 856..975.
//  3 Line wrap: word hc=1039,vc=0 followed by word hc=0,vc=1 (XC=0,YC=1,Active=1).
//  4 Frame wrap: VS=1 on lines 637..642 only (6*1040 cycles).
//    Word (1039,665) -> next (0,0) with frame_o=1.
//    frame_o period = 692640 cycles over 3 frames.
//  5 Polarity: HS_POL=0,VS_POL=0 -> HS low only 856..975, VS low only 637..642, both high otherwise.
//  6 Colour tracking: toggle bg_color every cycle in visible area -> RGB follows with 1-cycle latency.
//    Zero during blanking.

Source files
------------

// File: rtl/vga_sync_stream.sv
// Head of the RGB stream pipeline. It generates VGA raster timing and emits one registered
// 26-bit stream word per pixel clock, plus a start-of-frame pulse.
module vga_sync_stream #(
   parameter int H_VIS  = 800,
   parameter int H_FP   = 56,
   parameter int H_SYNC = 120,
   parameter int H_BP   = 64,
   parameter int V_VIS  = 600,
   parameter int V_FP   = 37,
   parameter int V_SYNC = 6,
   parameter int V_BP   = 23,
   parameter bit HS_POL = 1'b1,
   parameter bit VS_POL = 1'b1
) (
   input  logic        px_clk,
   input  logic        reset,
   input  logic [2:0]  bg_color,
   output logic [25:0] strRGB_o,
   output logic        frame_o
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS_W  = 11'(H_VIS);
   localparam logic [10:0] V_VIS_W  = 11'(V_VIS);
   localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);

   logic [10:0] hc;
   logic [10:0] vc;
   logic        active;
   logic        hs;
   logic        vs;
   logic [25:0] word_nxt;

   always_comb begin
      active   = (hc < H_VIS_W) && (vc < V_VIS_W);
      hs       = ((hc >= HS_START) && (hc < HS_END)) ? HS_POL : ~HS_POL;
      vs       = ((vc >= VS_START) && (vc < VS_END)) ? VS_POL : ~VS_POL;
      word_nxt = '0;
      word_nxt[0] = active;
      word_nxt[1] = vs;
      word_nxt[2] = hs;
      // Blanking forces coordinates and colour to zero so the 10-bit fields never overflow
      if (active) begin
         word_nxt[12:3]  = vc[9:0];
         word_nxt[22:13] = hc[9:0];
         word_nxt[25:23] = bg_color;
      end
   end

   always_ff @(posedge px_clk or posedge reset) begin
      if (reset) begin
         hc       <= '0;
         vc       <= '0;
         strRGB_o <= '0;
         frame_o  <= 1'b0;
      end else begin
         strRGB_o <= word_nxt;
         frame_o  <= (hc == 11'd0) && (vc == 11'd0);
         if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? 11'd0 : vc + 11'd1;
         end else begin
            hc <= hc + 11'd1;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_stream.sv
// Bench for vga_sync_stream. It runs one default-timing instance and two shrunken-raster
// instances (one per sync polarity), with a per-instance reference raster feeding a queue scoreboard.
module tb_vga_sync_stream;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] bg  = 3'b000;

   always #5 clk = ~clk;

   logic [25:0] str [3];
   logic        frm [3];

   localparam int HV[3]  = '{800, 16, 16};
   localparam int HF[3]  = '{56, 4, 4};
   localparam int HSY[3] = '{120, 6, 6};
   localparam int HB[3]  = '{64, 4, 4};
   localparam int VV[3]  = '{600, 8, 8};
   localparam int VF[3]  = '{37, 2, 2};
   localparam int VSY[3] = '{6, 3, 3};
   localparam int VB[3]  = '{23, 2, 2};
   localparam int HP[3]  = '{1, 1, 0};
   localparam int VP[3]  = '{1, 1, 0};

   vga_sync_stream u_def (
      .px_clk(clk), .reset(rst), .bg_color(bg), .strRGB_o(str[0]), .frame_o(frm[0])
   );

   vga_sync_stream #(
      .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
      .V_VIS(8), .V_FP(2), .V_SYNC(3), .V_BP(2), .HS_POL(1'b1), .VS_POL(1'b1)
   ) u_pos (
      .px_clk(clk), .reset(rst), .bg_color(bg), .strRGB_o(str[1]), .frame_o(frm[1])
   );

   vga_sync_stream #(
      .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
      .V_VIS(8), .V_FP(2), .V_SYNC(3), .V_BP(2), .HS_POL(1'b0), .VS_POL(1'b0)
   ) u_neg (
      .px_clk(clk), .reset(rst), .bg_color(bg), .strRGB_o(str[2]), .frame_o(frm[2])
   );

   int          checks = 0;
   int          passed = 0;
   int          cyc    = 0;
   int          m_hc [3];
   int          m_vc [3];
   int          last_frm [3];
   bit          toggle_mode = 1'b0;
   logic [26:0] sb0 [$];
   logic [26:0] sb1 [$];
   logic [26:0] sb2 [$];

   // Expected {frame, word} for raster position (hc, vc) of instance k
   function automatic logic [26:0] model(int k, int hc, int vc, logic [2:0] c);
      logic        act;
      logic        hs;
      logic        vs;
      logic [25:0] w;
      act = (hc < HV[k]) && (vc < VV[k]);
      hs  = (hc >= HV[k] + HF[k]) && (hc < HV[k] + HF[k] + HSY[k]);
      vs  = (vc >= VV[k] + VF[k]) && (vc < VV[k] + VF[k] + VSY[k]);
      if (HP[k] == 0) hs = ~hs;
      if (VP[k] == 0) vs = ~vs;
      w    = '0;
      w[0] = act;
      w[1] = vs;
      w[2] = hs;
      if (act) begin
         w[12:3]  = 10'(vc);
         w[22:13] = 10'(hc);
         w[25:23] = c;
      end
      return {(hc == 0) && (vc == 0), w};
   endfunction

   task automatic check(input string tag, input int k, input logic [25:0] got, input logic [25:0] exp);
      checks++;
      assert (got === exp) passed++;
      else $error("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", tag, k, cyc, got, exp);
   endtask

   task automatic push_word(input int k, input logic [26:0] e);
      case (k)
         0: sb0.push_back(e);
         1: sb1.push_back(e);
         default: sb2.push_back(e);
      endcase
   endtask

   task automatic pop_word(input int k, output bit ok, output logic [26:0] e);
      ok = 1'b0;
      e  = '0;
      case (k)
         0: if (sb0.size() > 0) begin e = sb0.pop_front(); ok = 1'b1; end
         1: if (sb1.size() > 0) begin e = sb1.pop_front(); ok = 1'b1; end
         default: if (sb2.size() > 0) begin e = sb2.pop_front(); ok = 1'b1; end
      endcase
   endtask

   // Drive the colour for the coming edge and queue the word each raster must produce from it
   task automatic drive_push();
      bg = toggle_mode ? 3'($urandom_range(0, 7)) : 3'b101;
      for (int k = 0; k < 3; k++) begin
         push_word(k, model(k, m_hc[k], m_vc[k], bg));
         if (m_hc[k] == HV[k] + HF[k] + HSY[k] + HB[k] - 1) begin
            m_hc[k] = 0;
            m_vc[k] = (m_vc[k] == VV[k] + VF[k] + VSY[k] + VB[k] - 1) ? 0 : m_vc[k] + 1;
         end else begin
            m_hc[k] = m_hc[k] + 1;
         end
      end
   endtask

   task automatic step(input int n);
      bit          ok;
      logic [26:0] e;
      int          period;
      repeat (n) begin
         @(negedge clk);
         cyc++;
         for (int k = 0; k < 3; k++) begin
            pop_word(k, ok, e);
            if (ok) begin
               check("word", k, str[k], e[25:0]);
               check("frame", k, {25'd0, frm[k]}, {25'd0, e[26]});
            end
            if (frm[k]) begin
               period = (HV[k] + HF[k] + HSY[k] + HB[k]) * (VV[k] + VF[k] + VSY[k] + VB[k]);
               if (last_frm[k] >= 0) check("frame_period", k, 26'(cyc - last_frm[k]), 26'(period));
               last_frm[k] = cyc;
            end
         end
         drive_push();
      end
   endtask

   task automatic check_reset_zero(input string tag);
      for (int k = 0; k < 3; k++) begin
         check({tag, "_word"}, k, str[k], 26'h0);
         check({tag, "_frame"}, k, {25'd0, frm[k]}, 26'h0);
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      sb0.delete();
      sb1.delete();
      sb2.delete();
      for (int k = 0; k < 3; k++) begin
         m_hc[k]     = 0;
         m_vc[k]     = 0;
         last_frm[k] = -1;
      end
      rst = 1'b0;
      drive_push();
   endtask

   initial begin
      for (int k = 0; k < 3; k++) last_frm[k] = -1;
      repeat (3) @(negedge clk);
      check_reset_zero("reset_init");
      release_reset();

      step(400);
      // Reset asserted between clock edges, mid-line: outputs must clear without a clock edge
      #2 rst = 1'b1;
      #1 check_reset_zero("reset_async");
      repeat (2) @(posedge clk);
      #1 check_reset_zero("reset_hold");
      release_reset();

      step(2200);
      toggle_mode = 1'b1;
      step(1500);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
